// File: rtl/intersection_sched_pkg.sv
// intersection_sched_pkg: shared traffic state encoding, timing defaults and helpers
package intersection_sched_pkg;
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
  localparam int DEF_YEL_TICKS   = 2;
  localparam int DEF_CLR_TICKS   = 1;
  localparam int DEF_GREEN_TICKS = 5;
  function automatic logic [3:0] max1(input logic [3:0] t);
    return t == 4'd0 ? 4'd1 : t;
  endfunction
endpackage

// File: rtl/intersection_sched_rr_pick.sv
// rr_pick: round-robin choice of the next light after active among requesters
module rr_pick (
  input  logic [1:0] active,
  input  logic [3:0] req,
  output logic [1:0] next
);
  // Offsets scanned farthest-first so the nearest requester wins; offset 4 is active itself.
  always_comb begin
    next = active + 2'd1;
    for (int i = 4; i >= 1; i--)
      if (req[active + 2'(i)]) next = active + 2'(i);
  end
endmodule

// File: rtl/intersection_sched.sv
// intersection_sched: four-way traffic light phase scheduler with pause and per-light green times
module intersection_sched import intersection_sched_pkg::*; #(
  parameter int YEL_TICKS = DEF_YEL_TICKS,
  parameter int CLR_TICKS = DEF_CLR_TICKS,
  parameter int DEF_GREEN = DEF_GREEN_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       go,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [3:0] cfg_time,
  input  logic [3:0] req,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] active,
  output logic [3:0] remaining,
  output logic       running
);
  state_t state_q, state_d;
  logic paused_q, paused_d, running_q, running_d;
  logic [1:0] act_q, act_d, next;
  logic [3:0] rem_q, rem_d, green_q, green_d, yellow_q, yellow_d, red_q, red_d;
  logic [3:0][3:0] cfg_q, cfg_d;

  rr_pick u_rr (.active(act_q), .req(req), .next(next));

  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    rem_d    = rem_q;
    act_d    = act_q;
    cfg_d    = cfg_q;
    if (cfg_we) cfg_d[cfg_sel] = cfg_time;
    // go takes priority; a tick on the same cycle is dropped so pause/resume never loses or gains one
    if (go) begin
      if (state_q == IDLE) begin
        state_d  = GREEN;
        act_d    = 2'd0;
        rem_d    = max1(cfg_q[0]);
        paused_d = 1'b0;
      end else paused_d = !paused_q;
    end else if (tick && !paused_q && state_q != IDLE) begin
      if (rem_q > 4'd1) rem_d = rem_q - 4'd1;
      else case (state_q)
        GREEN:   begin state_d = YELLOW; rem_d = 4'(YEL_TICKS); end
        YELLOW:  begin state_d = ALLRED; rem_d = 4'(CLR_TICKS); end
        ALLRED:  begin state_d = GREEN; act_d = next; rem_d = max1(cfg_q[next]); end
        default: state_d = IDLE;
      endcase
    end
    green_d   = state_d == GREEN  ? 4'd1 << act_d : 4'd0;
    yellow_d  = state_d == YELLOW ? 4'd1 << act_d : 4'd0;
    red_d     = ~(green_d | yellow_d);
    running_d = state_d != IDLE && !paused_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      paused_q  <= 1'b0;
      rem_q     <= 4'd0;
      act_q     <= 2'd0;
      cfg_q     <= {4{4'(DEF_GREEN)}};
      green_q   <= 4'd0;
      yellow_q  <= 4'd0;
      red_q     <= 4'hf;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paused_q  <= paused_d;
      rem_q     <= rem_d;
      act_q     <= act_d;
      cfg_q     <= cfg_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
      running_q <= running_d;
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign active    = act_q;
  assign remaining = rem_q;
  assign running   = running_q;
endmodule

// File: tb/tb_intersection_sched.sv
// tb_intersection_sched: directed vector table plus hand sequences for pause, cfg and reset corners
module tb_intersection_sched;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, go = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0, active;
  logic [3:0] cfg_time = 4'd0, req = 4'd0, green, yellow, red, remaining;
  logic running;
  int total = 0, passed = 0;

  intersection_sched dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .go(go), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_time(cfg_time), .req(req), .green(green), .yellow(yellow), .red(red),
    .active(active), .remaining(remaining), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic go, tick, we;
    logic [1:0] sel;
    logic [3:0] tm, rq, g, y;
    logic [1:0] act;
    logic [3:0] rem;
    logic run;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string n, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", n, got, exp);
  endtask

  task automatic chk_all(input string n, input logic [3:0] g, y, input logic [1:0] a,
                         input logic [3:0] r, input logic run);
    chk({n, ".green"}, green, g);
    chk({n, ".yellow"}, yellow, y);
    chk({n, ".red"}, red, ~(g | y));
    chk({n, ".active"}, 4'(active), 4'(a));
    chk({n, ".remaining"}, remaining, r);
    chk({n, ".running"}, 4'(running), 4'(run));
  endtask

  task automatic step(input logic g, t, w, input logic [1:0] s, input logic [3:0] tm, rq);
    go = g; tick = t; cfg_we = w; cfg_sel = s; cfg_time = tm; req = rq;
    @(posedge clk); #1;
    go = 1'b0; tick = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [3:0] rq);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, rq);
  endtask

  task automatic do_reset();
    go = 1'b0; tick = 1'b0; cfg_we = 1'b0; req = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Round robin with all requesting, then light 2 only; light 2 picks up the 3-tick green written during light 0
    v.push_back('{1,0,0,0,0,4'hf, 4'b0001,4'b0000,0,5,1});
    v.push_back('{0,1,1,2,3,4'hf, 4'b0001,4'b0000,0,4,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0001,4'b0000,0,3,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0001,4'b0000,0,2,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0001,4'b0000,0,1,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0000,4'b0001,0,2,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0000,4'b0001,0,1,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0000,4'b0000,0,1,1});
    v.push_back('{0,1,0,0,0,4'hf, 4'b0010,4'b0000,1,5,1});
    v.push_back('{0,0,0,0,0,4'h4, 4'b0010,4'b0000,1,5,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0010,4'b0000,1,4,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0010,4'b0000,1,3,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0010,4'b0000,1,2,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0010,4'b0000,1,1,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0000,4'b0010,1,2,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0000,4'b0010,1,1,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0000,4'b0000,1,1,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0100,4'b0000,2,3,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0100,4'b0000,2,2,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0100,4'b0000,2,1,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0000,4'b0100,2,2,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0000,4'b0100,2,1,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0000,4'b0000,2,1,1});
    v.push_back('{0,1,0,0,0,4'h4, 4'b0100,4'b0000,2,3,1});

    do_reset();
    chk_all("reset", 4'd0, 4'd0, 2'd0, 4'd0, 1'b0);
    ticks(2, 4'hf);
    chk_all("idle_ticks", 4'd0, 4'd0, 2'd0, 4'd0, 1'b0);
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].go, v[i].tick, v[i].we, v[i].sel, v[i].tm, v[i].rq);
      chk_all($sformatf("vec%0d", i), v[i].g, v[i].y, v[i].act, v[i].rem, v[i].run);
    end

    // Pause at remaining=3 with a same-cycle tick, ten ignored ticks, resume
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'hf);
    ticks(2, 4'hf);
    chk_all("pre_pause", 4'b0001, 4'd0, 2'd0, 4'd3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'hf);
    chk_all("paused", 4'b0001, 4'd0, 2'd0, 4'd3, 1'b0);
    ticks(10, 4'hf);
    chk_all("paused_10", 4'b0001, 4'd0, 2'd0, 4'd3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'hf);
    chk_all("resumed", 4'b0001, 4'd0, 2'd0, 4'd3, 1'b1);
    ticks(2, 4'hf);
    chk_all("resume_2", 4'b0001, 4'd0, 2'd0, 4'd1, 1'b1);
    ticks(1, 4'hf);
    chk_all("resume_3", 4'd0, 4'b0001, 2'd0, 4'd2, 1'b1);

    // go+tick+cfg_we together; light 1 gets a zero (one-tick) green; req=0 walks 1,2,3,0
    do_reset();
    step(1'b1, 1'b1, 1'b1, 2'd1, 4'd0, 4'h0);
    chk_all("go_tick", 4'b0001, 4'd0, 2'd0, 4'd5, 1'b1);
    ticks(5, 4'h0);
    chk_all("l0_yel", 4'd0, 4'b0001, 2'd0, 4'd2, 1'b1);
    ticks(3, 4'h0);
    chk_all("l1_green1", 4'b0010, 4'd0, 2'd1, 4'd1, 1'b1);
    ticks(1, 4'h0);
    chk_all("l1_yel", 4'd0, 4'b0010, 2'd1, 4'd2, 1'b1);
    ticks(3, 4'h0);
    chk_all("l2_green", 4'b0100, 4'd0, 2'd2, 4'd5, 1'b1);
    ticks(8, 4'h0);
    chk_all("l3_green", 4'b1000, 4'd0, 2'd3, 4'd5, 1'b1);
    ticks(8, 4'h0);
    chk_all("l0_wrap", 4'b0001, 4'd0, 2'd0, 4'd5, 1'b1);

    // Asynchronous reset mid-yellow restores cfg and holds in IDLE until go
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'hf);
    step(1'b0, 1'b1, 1'b1, 2'd0, 4'd2, 4'hf);
    ticks(5, 4'hf);
    chk_all("mid_yel", 4'd0, 4'b0001, 2'd0, 4'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 4'd0, 4'd0, 2'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    ticks(3, 4'hf);
    chk_all("post_rst_idle", 4'd0, 4'd0, 2'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'hf);
    chk_all("post_rst_go", 4'b0001, 4'd0, 2'd0, 4'd5, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/intersection_sched.md
INTERSECTION_SCHED -- requirements
Module: intersection_sched

Interface
REQ-001 Parameter YEL_TICKS, default 2, meaning: ticks each light spends in yellow.
REQ-002 Parameter CLR_TICKS, default 1, meaning: all-red clearance ticks between phases.
REQ-003 Parameter DEF_GREEN, default 5, meaning: per-light green time loaded at reset.
REQ-004 clk  in  1  system clock; all state changes on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-cycle timing enable; all timers advance only on cycles with tick=1.
REQ-007 go  in  1  one-cycle pulse; toggles run/pause.
REQ-008 cfg_we  in  1  one-cycle pulse; writes cfg_time into green-time register cfg_sel.
REQ-009 cfg_sel  in  2  light index for cfg_we.
REQ-010 cfg_time  in  4  green duration in ticks.
REQ-011 req  in  4  per-light demand (car sensor), level.
REQ-012 green  out  4  one-hot or zero; green lamp per light.
REQ-013 yellow  out  4  one-hot or zero; yellow lamp per light.
REQ-014 red  out  4  complement of (green|yellow).
REQ-015 active  out  2  index of light currently owning the phase.
REQ-016 remaining  out  4  ticks left in current timed state.
REQ-017 running  out  1  high when not paused and not IDLE.

Function
REQ-018 FSM states IDLE, GREEN, YELLOW, ALLRED; at most one light non-red at any cycle.
REQ-019 IDLE: all red; first go pulse enters GREEN for light 0, remaining=max(cfg[0],1).
REQ-020 GREEN: on tick, remaining decrements; on tick with remaining=1, go to YELLOW, remaining=YEL_TICKS.
REQ-021 YELLOW: on tick with remaining=1, go to ALLRED, remaining=CLR_TICKS.
REQ-022 ALLRED: on tick with remaining=1, select next light and enter GREEN, remaining=max(cfg[next],1).
REQ-023 Next light: first index after active, round-robin modulo 4, with req set; if req=0, active+1 mod 4; if only active requests, active again.
REQ-024 cfg_time=0 treated as 1 tick; cfg writes take effect at the next GREEN load, never mid-phase.
REQ-025 Running, go pulse pauses: state, lamps, remaining frozen; ticks ignored; next go resumes with no lost or extra tick.
REQ-026 go and tick on same cycle: go wins, tick discarded.
REQ-027 cfg_we and go on same cycle: both take effect.
REQ-028 Outputs registered; lamps change on the cycle after the qualifying tick (latency 1).
REQ-029 req sampled only on the ALLRED->GREEN transition cycle.

Reset
REQ-030 rst_n low asynchronously forces: IDLE, green=0, yellow=0, red=4'b1111, active=0, remaining=0, running=0, all cfg=DEF_GREEN.
REQ-031 Reset mid-phase abandons the phase; after release, block waits in IDLE for go.

Structure
REQ-032 State encoding and the DEF_GREEN/YEL_TICKS/CLR_TICKS defaults live in the shared traffic package.
REQ-033 Round-robin next-light selection is one sub-module, rr_pick (inputs active, req; output next).
REQ-034 Implementation targets 120-400 lines; no derived clocks, tick is an enable only.

Verification
REQ-035 Reset, go, req=4'b1111, every cycle tick -> light0 green 5 ticks, yellow 2, all-red 1, then light1 green.
REQ-036 cfg_we sel=2 time=3 while light0 green -> light0 phase unchanged; light2 later gets 3-tick green.
REQ-037 req=4'b0100 steady, active=0 -> sequence 0,2,2,2...; req=0 -> 0,1,2,3,0.
REQ-038 go during GREEN at remaining=3, 10 ticks, go -> remaining still 3, phase completes 3 ticks later.
REQ-039 cfg_time=0 for light1 -> light1 green exactly 1 tick; go+tick same cycle -> tick discarded.
REQ-040 rst_n low mid-YELLOW -> all red, IDLE immediately, cfg back to 5; no activity until go.
